// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg
// Shared definitions for the alu_pipe block: the opcode encoding and the
// constants that do not depend on the operand width.
//
// Contents:
//   OPCODE_W  - width of the opcode field
//   alu_op_e  - opcode enumeration used by the pipeline and the datapath
//   is_arith  - true for the opcodes that compute at full precision (ADD/SUB)
package alu_pipe_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_NOT   = 3'b010,
    OP_REDOR = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_ASR   = 3'b111
  } alu_op_e;

  // ADD and SUB are the only operations that can leave the WIDTH-bit signed
  // range, so they alone drive the overflow flag (and saturation, if built).
  function automatic logic is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core
// Purely combinational ALU datapath sitting between the two pipeline stages
// of alu_pipe.
//
// Parameters:
//   WIDTH  operand width (power of two, 2..32)
// Ports:
//   op    in   opcode (alu_op_e)
//   a, b  in   signed WIDTH-bit operands
//   c     out  signed WIDTH+1-bit result
//   zero  out  c == 0
//   ovf   out  ADD/SUB true result outside the WIDTH-bit signed range
//
// Build option: define ALU_PIPE_SAT_EN to clamp ADD/SUB results to the
// WIDTH-bit signed range (ovf still reports the clamp).
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  alu_op_e                 op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH:0]   c,
  output logic                    zero,
  output logic                    ovf
);

  localparam int SHW = $clog2(WIDTH);

  logic signed [WIDTH:0]   a_ext;
  logic signed [WIDTH:0]   b_ext;
  logic signed [WIDTH:0]   arith;
  logic signed [WIDTH-1:0] narrow;
  logic                    arith_ovf;

  // ADD/SUB are done one bit wider than the operands so the true result is
  // always representable; the top two bits disagreeing means it no longer
  // fits in WIDTH signed bits.
  always_comb begin
    a_ext = {a[WIDTH-1], a};
    b_ext = {b[WIDTH-1], b};
    if (op == OP_SUB) begin
      arith = a_ext - b_ext;
    end else begin
      arith = a_ext + b_ext;
    end
    arith_ovf = arith[WIDTH] ^ arith[WIDTH-1];
  end

  // The bitwise and shift operations produce a WIDTH-bit value that is then
  // sign-extended.  The shift amount uses only the low log2(WIDTH) bits of b,
  // read as unsigned, while a is shifted arithmetically.
  always_comb begin
    narrow = '0;
    case (op)
      OP_NOT:  narrow = ~a;
      OP_AND:  narrow = a & b;
      OP_OR:   narrow = a | b;
      OP_XOR:  narrow = a ^ b;
      OP_ASR:  narrow = a >>> b[SHW-1:0];
      default: narrow = '0;
    endcase
  end

`ifdef ALU_PIPE_SAT_EN
  logic signed [WIDTH:0] sat_min;
  logic signed [WIDTH:0] sat_max;

  // Saturating build: on overflow the sign of the wide result tells which
  // rail to clamp to; both rails are already sign-extended to WIDTH+1.
  always_comb begin
    sat_min = {2'b11, {(WIDTH-1){1'b0}}};
    sat_max = {2'b00, {(WIDTH-1){1'b1}}};
    c = {narrow[WIDTH-1], narrow};
    if (op == OP_REDOR) begin
      c = {{WIDTH{1'b0}}, |b};
    end else if (is_arith(op)) begin
      if (arith_ovf) begin
        c = arith[WIDTH] ? sat_min : sat_max;
      end else begin
        c = arith;
      end
    end
  end
`else
  // Default build: ADD/SUB hand back the full WIDTH+1 result, REDOR is the
  // zero-extended OR-reduction of b, everything else is sign-extended.
  always_comb begin
    c = {narrow[WIDTH-1], narrow};
    if (op == OP_REDOR) begin
      c = {{WIDTH{1'b0}}, |b};
    end else if (is_arith(op)) begin
      c = arith;
    end
  end
`endif

  // Flags are derived from the final result so that zero reflects any
  // clamping, and overflow is only meaningful for ADD/SUB.
  always_comb begin
    zero = (c == '0);
    ovf  = is_arith(op) && arith_ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
// Two-stage pipelined signed ALU with valid/ready handshaking on both sides.
// Stage 1 registers the operands and opcode, the combinational datapath
// (alu_pipe_core) sits between the stages, and stage 2 registers the result
// and flags that drive the outputs.  Full throughput when the consumer is
// always ready; up to two operations are held under backpressure.
//
// Parameters:
//   WIDTH      operand width (power of two, 2..32), default 4
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand transfer request
//   in_ready   out  operand transfer can be accepted this cycle
//   a, b       in   signed WIDTH-bit operands
//   opcode     in   3-bit operation select (alu_op_e)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   c          out  signed WIDTH+1-bit result
//   zero, ovf  out  result-is-zero and signed-overflow flags
//
// Build option: ALU_PIPE_SAT_EN enables saturation of ADD/SUB results.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [OPCODE_W-1:0]     opcode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH:0]   c,
  output logic                    zero,
  output logic                    ovf
);

  logic                    s1_valid;
  logic signed [WIDTH-1:0] s1_a;
  logic signed [WIDTH-1:0] s1_b;
  alu_op_e                 s1_op;
  logic                    s2_valid;
  logic                    s1_adv;
  logic                    s2_adv;
  logic signed [WIDTH:0]   core_c;
  logic                    core_zero;
  logic                    core_ovf;

  // Ready chain: a stage may take new contents when it is empty or when the
  // stage after it is moving.  Because stage 2 draining feeds straight into
  // stage 1 advancing, a drain and a fill in the same cycle lose nothing.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !rst;
  assign out_valid = s2_valid;

  // Stage 1 valid bit.  Whenever stage 1 is allowed to move it simply takes
  // whatever in_valid says, which also empties it when nothing arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 operand registers.  These are only meaningful while s1_valid is
  // set, so they carry no reset and load only on an actual transfer.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_a  <= a;
      s1_b  <= b;
      s1_op <= alu_op_e'(opcode);
    end
  end

  alu_pipe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op   (s1_op),
    .a    (s1_a),
    .b    (s1_b),
    .c    (core_c),
    .zero (core_zero),
    .ovf  (core_ovf)
  );

  // Stage 2 holds the visible result.  Result registers load only when a
  // valid operation moves in, so c/zero/ovf stay frozen while the consumer
  // stalls; reset clears them along with the valid bit so nothing stale is
  // presented afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      c        <= '0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        c    <= core_c;
        zero <= core_zero;
        ovf  <= core_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
// Self-checking bench for alu_pipe at WIDTH=4.  Every accepted operation
// pushes its expected result into a queue; an independent monitor compares
// whatever the DUT presents against the head of that queue and pops it when
// the consumer takes the result.  Define ALU_PIPE_SAT_EN for both the bench
// and the RTL to exercise the saturating build.
module tb_alu_pipe;

  localparam int W  = 4;
  localparam int LO = -(1 << (W - 1));
  localparam int HI = (1 << (W - 1)) - 1;

  typedef struct {
    int c;
    bit zero;
    bit ovf;
  } exp_t;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic [2:0]   opcode    = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W:0]   c;
  logic         zero;
  logic         ovf;

  exp_t scoreQ[$];
  int   compared     = 0;
  int   mismatched   = 0;
  int   cycle        = 0;
  int   lastPopCycle = -10;
  int   streak       = 0;
  int   maxStreak    = 0;
  int   popCount     = 0;
  bit   randReady    = 1'b0;

  alu_pipe #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .zero      (zero),
    .ovf       (ovf)
  );

  // Free-running clock and a cycle counter used to spot back-to-back results.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: evaluates each opcode on plain integers holding the
  // signed operand values, then applies the range rules for ADD/SUB.
  function automatic exp_t model(input logic [2:0] op, input int av, input int bv);
    exp_t e;
    int   r;
    e.ovf = 1'b0;
    case (op)
      3'd0:    r = av + bv;
      3'd1:    r = av - bv;
      3'd2:    r = -av - 1;
      3'd3:    r = (bv != 0) ? 1 : 0;
      3'd4:    r = av & bv;
      3'd5:    r = av | bv;
      3'd6:    r = av ^ bv;
      default: r = av >>> (bv & (W - 1));
    endcase
    if (op <= 3'd1 && (r < LO || r > HI)) begin
      e.ovf = 1'b1;
`ifdef ALU_PIPE_SAT_EN
      r = (r < LO) ? LO : HI;
`endif
    end
    e.c    = r;
    e.zero = (r == 0);
    return e;
  endfunction

  function automatic exp_t mkExp(input int cv, input bit zv, input bit ov);
    exp_t e;
    e.c    = cv;
    e.zero = zv;
    e.ovf  = ov;
    return e;
  endfunction

  task automatic checkOutput(input string name, input integer actual, input integer expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Drives one operation for one cycle starting just after a rising edge.
  // The handshake is judged at the falling edge, where inputs are stable,
  // and the expectation is queued only if the DUT takes the transfer.
  task automatic applyStimulus(input logic [2:0] op, input int av, input int bv,
                               input exp_t e, output bit accepted);
    in_valid = 1'b1;
    opcode   = op;
    a        = av[W-1:0];
    b        = bv[W-1:0];
    @(negedge clk);
    accepted = in_ready;
    if (accepted) scoreQ.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Keeps offering the same operation until it is accepted or the retry
  // budget runs out.
  task automatic issue(input logic [2:0] op, input int av, input int bv, input exp_t e);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 30) begin
      applyStimulus(op, av, bv, e, acc);
      tries++;
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL issue_timeout: op %0d never accepted after %0d tries", op, tries);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for every queued expectation to be consumed.
  task automatic waitDrain();
    int n;
    n        = 0;
    in_valid = 1'b0;
    while (scoreQ.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", scoreQ.size(), 0);
  endtask

  // Monitor: while a result is presented it must match the oldest pending
  // expectation (which also proves it holds steady under backpressure); the
  // expectation is retired only when out_ready takes it.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (scoreQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL stray_result: out_valid with c=%0d but nothing pending (cycle %0d)",
                 $signed(c), cycle);
      end else begin
        checkOutput("result_c", $signed(c), scoreQ[0].c);
        checkOutput("result_zero", zero, scoreQ[0].zero);
        checkOutput("result_ovf", ovf, scoreQ[0].ovf);
        if (out_ready) begin
          void'(scoreQ.pop_front());
          popCount++;
          if (cycle == lastPopCycle + 1) streak++;
          else streak = 1;
          lastPopCycle = cycle;
          if (streak > maxStreak) maxStreak = streak;
        end
      end
    end
  end

  // Random consumer backpressure, active only while randReady is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit acc;
    int pops0;
    int av;
    int bv;
    logic [2:0] op;

    // Reset state.
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_c", c, 0);
    checkOutput("rst_zero", zero, 0);
    checkOutput("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Directed operations, including the two-cycle latency of the first.
`ifdef ALU_PIPE_SAT_EN
    applyStimulus(3'd0, 7, 1, mkExp(7, 0, 1), acc);
`else
    applyStimulus(3'd0, 7, 1, mkExp(8, 0, 1), acc);
`endif
    checkOutput("add_accept", acc, 1);
    @(negedge clk);
    checkOutput("latency_cycle1", out_valid, 0);
    @(negedge clk);
    checkOutput("latency_cycle2", out_valid, 1);
    @(posedge clk);
    #1;
`ifdef ALU_PIPE_SAT_EN
    issue(3'd1, -8, 1, mkExp(-8, 0, 1));
    issue(3'd0, -8, -8, mkExp(-8, 0, 1));
`else
    issue(3'd1, -8, 1, mkExp(-9, 0, 1));
    issue(3'd0, -8, -8, mkExp(-16, 0, 1));
`endif
    issue(3'd2, 5, 0, mkExp(-6, 0, 0));
    issue(3'd3, 0, 0, mkExp(0, 1, 0));
    issue(3'd3, 0, 4, mkExp(1, 0, 0));
    issue(3'd7, -8, 2, mkExp(-2, 0, 0));
    issue(3'd7, 7, 3, mkExp(0, 1, 0));
    issue(3'd7, -8, 7, mkExp(-1, 0, 0));
    issue(3'd1, 3, 3, mkExp(0, 1, 0));
    waitDrain();

    // Backpressure: two operations fill the pipe, the third is refused.
    idle(1);
    out_ready = 1'b0;
    pops0     = popCount;
    applyStimulus(3'd0, 1, 1, mkExp(2, 0, 0), acc);
    checkOutput("bp_accept1", acc, 1);
    applyStimulus(3'd0, 2, 2, mkExp(4, 0, 0), acc);
    checkOutput("bp_accept2", acc, 1);
    applyStimulus(3'd0, 3, 3, mkExp(6, 0, 0), acc);
    checkOutput("bp_accept3", acc, 0);
    idle(3);
    checkOutput("bp_held_pops", popCount - pops0, 0);
    out_ready = 1'b1;
    issue(3'd0, 3, 3, mkExp(6, 0, 0));
    waitDrain();
    checkOutput("bp_result_count", popCount - pops0, 3);

    // Full throughput: eight random operations back to back.
    idle(2);
    maxStreak = 0;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7));
      av = int'($urandom_range(0, 15)) - 8;
      bv = int'($urandom_range(0, 15)) - 8;
      applyStimulus(op, av, bv, model(op, av, bv), acc);
      checkOutput("tp_accept", acc, 1);
    end
    waitDrain();
    checkOutput("tp_consecutive", maxStreak, 8);

    // Random operations against random consumer stalls.
    randReady = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      av = int'($urandom_range(0, 15)) - 8;
      bv = int'($urandom_range(0, 15)) - 8;
      issue(op, av, bv, model(op, av, bv));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    randReady = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    // Reset with two operations in flight: both must vanish.
    idle(1);
    out_ready = 1'b0;
    issue(3'd0, 1, 2, mkExp(3, 0, 0));
    issue(3'd6, 5, 3, mkExp(6, 0, 0));
    rst = 1'b1;
    scoreQ.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_out_valid", out_valid, 0);
    checkOutput("rstmid_c", c, 0);
    checkOutput("rstmid_zero", zero, 0);
    checkOutput("rstmid_ovf", ovf, 0);
    checkOutput("rstmid_in_ready", in_ready, 1);
    pops0 = popCount;
    @(posedge clk);
    #1;
    idle(5);
    checkOutput("rstmid_no_stale", popCount - pops0, 0);

    // One last operation to show the pipe works after reset.
    issue(3'd4, -3, 6, model(3'd4, -3, 6));
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
